// File: rtl/calc_exec_ctrl.sv
// Execution sequencer for the small calculator: reads two RF operands, runs a 3-bit ALU op and
// writes the result back. Optional registered flags are built when CALC_FLAGS_EN is defined.
module calc_exec_ctrl #(
   parameter int unsigned DW = 3,
   parameter int unsigned AW = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          instr_valid,
   output logic          instr_ready,
   input  logic [2:0]    op,
   input  logic [AW-1:0] srca,
   input  logic [AW-1:0] srcb,
   input  logic [AW-1:0] dst,
   input  logic [DW-1:0] imm,
   output logic          rf_rea,
   output logic          rf_reb,
   output logic [AW-1:0] rf_raa,
   output logic [AW-1:0] rf_rab,
   input  logic [DW-1:0] rf_douta,
   input  logic [DW-1:0] rf_doutb,
   output logic          rf_we,
   output logic [AW-1:0] rf_wa,
   output logic [DW-1:0] rf_din,
   output logic          done,
   output logic          flag_z,
   output logic          flag_c
);

   typedef enum logic [1:0] {StIdle, StRead, StExec, StWrite} state_e;

   localparam logic [2:0] OpAdd = 3'b000;
   localparam logic [2:0] OpSub = 3'b001;
   localparam logic [2:0] OpAnd = 3'b010;
   localparam logic [2:0] OpOr  = 3'b011;
   localparam logic [2:0] OpXor = 3'b100;
   localparam logic [2:0] OpNot = 3'b101;
   localparam logic [2:0] OpMov = 3'b110;
   localparam logic [2:0] OpLdi = 3'b111;

   state_e          state_q, state_d;
   logic [2:0]      op_q, op_d;
   logic [AW-1:0]   sa_q, sa_d, sb_q, sb_d, dst_q, dst_d;
   logic [DW-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
   logic [DW-1:0]   alu_res;
`ifdef CALC_FLAGS_EN
   logic            alu_carry;
   logic            carry_q, carry_d;
   logic            flag_z_q, flag_z_d, flag_c_q, flag_c_d;
`endif

   always_comb begin
      alu_res = '0;
`ifdef CALC_FLAGS_EN
      alu_carry = 1'b0;
`endif
      unique case (op_q)
`ifdef CALC_FLAGS_EN
         OpAdd: {alu_carry, alu_res} = {1'b0, a_q} + {1'b0, b_q};
         OpSub: begin
            alu_res   = a_q - b_q;
            alu_carry = (a_q < b_q);
         end
`else
         OpAdd: alu_res = a_q + b_q;
         OpSub: alu_res = a_q - b_q;
`endif
         OpAnd: alu_res = a_q & b_q;
         OpOr:  alu_res = a_q | b_q;
         OpXor: alu_res = a_q ^ b_q;
         OpNot: alu_res = ~a_q;
         OpMov: alu_res = a_q;
         OpLdi: alu_res = res_q;
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      sa_d        = sa_q;
      sb_d        = sb_q;
      dst_d       = dst_q;
      a_d         = a_q;
      b_d         = b_q;
      res_d       = res_q;
      instr_ready = 1'b0;
      rf_rea      = 1'b0;
      rf_reb      = 1'b0;
      rf_raa      = '0;
      rf_rab      = '0;
      rf_we       = 1'b0;
      rf_wa       = '0;
      rf_din      = '0;
      done        = 1'b0;
`ifdef CALC_FLAGS_EN
      carry_d     = carry_q;
      flag_z_d    = flag_z_q;
      flag_c_d    = flag_c_q;
`endif
      unique case (state_q)
         StIdle: begin
            instr_ready = 1'b1;
            if (instr_valid) begin
               op_d  = op;
               sa_d  = srca;
               sb_d  = srcb;
               dst_d = dst;
               // LDI skips the operand phases; the immediate goes straight to the result reg.
               if (op == OpLdi) begin
                  res_d   = imm;
`ifdef CALC_FLAGS_EN
                  carry_d = 1'b0;
`endif
                  state_d = StWrite;
               end else begin
                  state_d = StRead;
               end
            end
         end
         StRead: begin
            rf_rea  = 1'b1;
            rf_reb  = 1'b1;
            rf_raa  = sa_q;
            rf_rab  = sb_q;
            a_d     = rf_douta;
            b_d     = rf_doutb;
            state_d = StExec;
         end
         StExec: begin
            res_d   = alu_res;
`ifdef CALC_FLAGS_EN
            carry_d = alu_carry;
`endif
            state_d = StWrite;
         end
         StWrite: begin
            rf_we    = 1'b1;
            rf_wa    = dst_q;
            rf_din   = res_q;
            done     = 1'b1;
`ifdef CALC_FLAGS_EN
            flag_z_d = (res_q == '0);
            flag_c_d = carry_q;
`endif
            state_d  = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         op_q     <= '0;
         sa_q     <= '0;
         sb_q     <= '0;
         dst_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         res_q    <= '0;
`ifdef CALC_FLAGS_EN
         carry_q  <= 1'b0;
         flag_z_q <= 1'b0;
         flag_c_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
         dst_q    <= dst_d;
         a_q      <= a_d;
         b_q      <= b_d;
         res_q    <= res_d;
`ifdef CALC_FLAGS_EN
         carry_q  <= carry_d;
         flag_z_q <= flag_z_d;
         flag_c_q <= flag_c_d;
`endif
      end
   end

`ifdef CALC_FLAGS_EN
   assign flag_z = flag_z_q;
   assign flag_c = flag_c_q;
`else
   assign flag_z = 1'b0;
   assign flag_c = 1'b0;
`endif

endmodule
